router_dest_reader: RTL

- Destination-side consumer for one router output port. It is the other end of the synchronizer's vld/re handshake.
- Watches the port's valid flag, waits a programmable response delay, then issues FIFO read enables to pull one complete packet: header, payload, parity.
- Streams payload bytes out, checks parity and destination address, and pulses a done flag.
- Always starts reading within 30 cycles of valid, so the synchronizer's soft-reset timeout is never reached in normal operation.

---
 rtl/router_pkg.sv | 33 +++
 rtl/router_parity_acc.sv | 30 +++
 rtl/router_dest_reader.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the router: header field layout, size limits and the
// destination-reader state encoding.
package router_pkg;

    localparam int DATA_W          = 8;
    localparam int LEN_MSB         = 7;
    localparam int LEN_LSB         = 2;
    localparam int ADDR_W          = 2;
    localparam int MAX_PAYLOAD     = 63;
    localparam int SFT_RST_TIMEOUT = 30;
    localparam int LEN_W           = $clog2(MAX_PAYLOAD + 1);
    localparam int DCNT_W          = $clog2(SFT_RST_TIMEOUT);

    typedef enum logic [2:0] {
        RD_IDLE = 3'd0,
        RD_WAIT = 3'd1,
        RD_HDR  = 3'd2,
        RD_HCAP = 3'd3,
        RD_PAY  = 3'd4,
        RD_PAR  = 3'd5,
        RD_CHK  = 3'd6,
        RD_DONE = 3'd7
    } rd_state_e;

    function automatic logic [LEN_W-1:0] hdr_len(input logic [DATA_W-1:0] hdr);
        return hdr[LEN_MSB:LEN_LSB];
    endfunction

    function automatic logic [ADDR_W-1:0] hdr_addr(input logic [DATA_W-1:0] hdr);
        return hdr[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/router_parity_acc.sv
// Byte-wide XOR accumulator with clear, load and fold controls; shared by the
// source-side checker and the destination reader.
module router_parity_acc #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic         xor_en,
    input  logic [W-1:0] din,
    output logic [W-1:0] acc
);

    logic [W-1:0] acc_r;

    // Accumulator register; clear beats load, load beats fold.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc_r <= {W{1'b0}};
        end else if (load) begin
            acc_r <= din;
        end else if (xor_en) begin
            acc_r <= acc_r ^ din;
        end
    end

    assign acc = acc_r;

endmodule

// File: rtl/router_dest_reader.sv
// Destination-side packet reader: waits a fixed response delay after vld, then
// pulls header, payload and parity from the port FIFO and reports the result.
module router_dest_reader #(
    parameter int                          DATA_W     = router_pkg::DATA_W,
    parameter logic [router_pkg::ADDR_W-1:0] PORT_ID  = 2'd0,
    parameter int                          RESP_DELAY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vld,
    input  logic              sft_rst,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] data_out,
    input  logic              hold,
    output logic              re,
    output logic              busy,
    output logic [DATA_W-1:0] byte_out,
    output logic              byte_vld,
    output logic [5:0]        pkt_len,
    output logic              pkt_done,
    output logic              parity_err,
    output logic              addr_err,
    output logic              pkt_drop
);

    import router_pkg::*;

    localparam logic [DCNT_W-1:0] DLY_LOAD = DCNT_W'(RESP_DELAY - 1);
    localparam logic [LEN_W-1:0]  REM_LAST = LEN_W'(1);

    rd_state_e         state_r, nxt_s;
    logic [DCNT_W-1:0] dcnt_r;
    logic [LEN_W-1:0]  rem_r;
    logic [ADDR_W-1:0] addr_r;
    logic              re_s, re_q_r, abort_s;
    logic              par_load_s, par_xor_s;
    logic [DATA_W-1:0] par_s;
    logic              busy_r, byte_vld_r, pkt_done_r, pkt_drop_r;
    logic              parity_err_r, addr_err_r;
    logic [DATA_W-1:0] byte_out_r;
    logic [LEN_W-1:0]  pkt_len_r;

    assign abort_s    = (state_r != RD_IDLE) && sft_rst;
    assign par_load_s = (state_r == RD_HCAP) && !abort_s;
    assign par_xor_s  = ((state_r == RD_PAY) || (state_r == RD_PAR)) && re_q_r && !abort_s;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RD_IDLE;
        end else begin
            state_r <= nxt_s;
        end
    end

    // Next-state logic; a soft reset outside IDLE always wins.
    always_comb begin
        nxt_s = state_r;
        if (abort_s) begin
            nxt_s = RD_IDLE;
        end else begin
            case (state_r)
                RD_IDLE: nxt_s = vld ? RD_WAIT : RD_IDLE;
                RD_WAIT: nxt_s = (dcnt_r == {DCNT_W{1'b0}}) ? RD_HDR : RD_WAIT;
                RD_HDR:  nxt_s = re_s ? RD_HCAP : RD_HDR;
                RD_HCAP: nxt_s = (hdr_len(data_out) == {LEN_W{1'b0}}) ? RD_PAR : RD_PAY;
                RD_PAY:  nxt_s = (re_s && (rem_r == REM_LAST)) ? RD_PAR : RD_PAY;
                RD_PAR:  nxt_s = re_s ? RD_CHK : RD_PAR;
                RD_CHK:  nxt_s = RD_DONE;
                RD_DONE: nxt_s = RD_IDLE;
                default: nxt_s = RD_IDLE;
            endcase
        end
    end

    // FIFO read enable; never read while the FIFO is being flushed.
    always_comb begin
        re_s = 1'b0;
        case (state_r)
            RD_HDR:  re_s = !fifo_empty;
            RD_PAY:  re_s = !hold && !fifo_empty;
            RD_PAR:  re_s = !fifo_empty;
            default: re_s = 1'b0;
        endcase
        if (sft_rst) begin
            re_s = 1'b0;
        end else begin
            re_s = re_s;
        end
    end

    router_parity_acc #(.W(DATA_W)) u_par (
        .clk    (clk),
        .rst    (rst),
        .clr    (abort_s),
        .load   (par_load_s),
        .xor_en (par_xor_s),
        .din    (data_out),
        .acc    (par_s)
    );

    // Counters, captured header fields and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            dcnt_r       <= {DCNT_W{1'b0}};
            rem_r        <= {LEN_W{1'b0}};
            addr_r       <= {ADDR_W{1'b0}};
            re_q_r       <= 1'b0;
            busy_r       <= 1'b0;
            byte_out_r   <= {DATA_W{1'b0}};
            byte_vld_r   <= 1'b0;
            pkt_len_r    <= {LEN_W{1'b0}};
            pkt_done_r   <= 1'b0;
            parity_err_r <= 1'b0;
            addr_err_r   <= 1'b0;
            pkt_drop_r   <= 1'b0;
        end else begin
            re_q_r     <= re_s;
            byte_vld_r <= 1'b0;
            pkt_done_r <= 1'b0;
            pkt_drop_r <= 1'b0;
            busy_r     <= (nxt_s != RD_IDLE) && (nxt_s != RD_DONE);
            if (abort_s) begin
                pkt_drop_r <= 1'b1;
                dcnt_r     <= {DCNT_W{1'b0}};
            end else begin
                case (state_r)
                    RD_IDLE: if (vld) dcnt_r <= DLY_LOAD;
                    RD_WAIT: if (dcnt_r != {DCNT_W{1'b0}}) dcnt_r <= dcnt_r - DCNT_W'(1);
                    RD_HCAP: begin
                        pkt_len_r <= hdr_len(data_out);
                        rem_r     <= hdr_len(data_out);
                        addr_r    <= hdr_addr(data_out);
                    end
                    RD_PAY: begin
                        if (re_s) rem_r <= rem_r - REM_LAST;
                        if (re_q_r) begin
                            byte_out_r <= data_out;
                            byte_vld_r <= 1'b1;
                        end
                    end
                    // The last payload byte can still be in flight here.
                    RD_PAR: begin
                        if (re_q_r) begin
                            byte_out_r <= data_out;
                            byte_vld_r <= 1'b1;
                        end
                    end
                    RD_CHK: begin
                        parity_err_r <= (par_s != data_out);
                        addr_err_r   <= (addr_r != PORT_ID);
                        pkt_done_r   <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign re         = re_s;
    assign busy       = busy_r;
    assign byte_out   = byte_out_r;
    assign byte_vld   = byte_vld_r;
    assign pkt_len    = pkt_len_r;
    assign pkt_done   = pkt_done_r;
    assign parity_err = parity_err_r;
    assign addr_err   = addr_err_r;
    assign pkt_drop   = pkt_drop_r;

endmodule
